// File: rtl/rr_ff_arbiter_if.sv
// Request/grant bundle between N producers and the shared capture register.
// The master side drives req/din; the arbiter (slave) drives the rest.
interface rr_ff_arbiter_if #(
  parameter int N = 4,
  parameter int W = 1
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]   req;
  logic [N*W-1:0] din;
  logic [N-1:0]   grant;
  logic [IW-1:0]  grant_id;
  logic           busy;
  logic [W-1:0]   q;
  logic           q_valid;

  modport master (
    output req, din,
    input  grant, grant_id, busy, q, q_valid
  );

  modport slave (
    input  req, din,
    output grant, grant_id, busy, q, q_valid
  );
endinterface

// File: rtl/rr_ff_arbiter.sv
// Round-robin arbiter with max-hold rotation feeding one shared
// W-bit capture register; all outputs come straight from flops.
module rr_ff_arbiter #(
  parameter int N        = 4,
  parameter int W        = 1,
  parameter int MAX_HOLD = 8
) (
  input  logic          clk,
  input  logic          rst,
  rr_ff_arbiter_if.slave bus
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int HW = $clog2(MAX_HOLD + 1);

  typedef enum logic {IDLE, OWN} state_t;

  state_t        state;
  logic [N-1:0]  grant_r;
  logic [IW-1:0] gid;
  logic [IW-1:0] last;
  logic [HW-1:0] hold;
  logic [W-1:0]  q_r;
  logic          qv_r;

  logic [W-1:0]  dsl [N];
  logic [N-1:0]  own_oh;
  logic [N-1:0]  mask;
  logic          found;
  logic [IW-1:0] win;
  logic [N-1:0]  win_oh;
  logic          own_req;
  logic          at_max;

  for (genvar i = 0; i < N; i++) begin : g_din
    assign dsl[i] = bus.din[i*W +: W];
  end

  // Owner is masked out while OWN so it never wins its own re-search.
  assign own_oh = (state == OWN) ? (N'(1) << gid) : '0;
  assign mask   = bus.req & ~own_oh;

  always_comb begin
    int idx;
    found = 1'b0;
    win   = '0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last) + k) % N;
      if (!found && mask[IW'(idx)]) begin
        found = 1'b1;
        win   = IW'(idx);
      end
    end
  end

  assign win_oh  = N'(1) << win;
  assign own_req = bus.req[gid];
  assign at_max  = (hold == HW'(MAX_HOLD));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      grant_r <= '0;
      gid     <= '0;
      last    <= IW'(N - 1);
      hold    <= '0;
      q_r     <= '0;
      qv_r    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          qv_r <= 1'b0;
          if (found) begin
            grant_r <= win_oh;
            gid     <= win;
            last    <= win;
            hold    <= HW'(1);
            state   <= OWN;
          end
        end
        OWN: begin
          if (own_req && grant_r[gid]) begin
            q_r  <= dsl[gid];
            qv_r <= 1'b1;
          end else begin
            qv_r <= 1'b0;
          end
          if (!own_req || at_max) begin
            if (found) begin
              grant_r <= win_oh;
              gid     <= win;
              last    <= win;
              hold    <= HW'(1);
            end else if (!own_req) begin
              grant_r <= '0;
              hold    <= '0;
              state   <= IDLE;
            end else begin
              hold <= HW'(1);
            end
          end else begin
            hold <= hold + HW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.grant    = grant_r;
  assign bus.grant_id = gid;
  assign bus.busy     = |grant_r;
  assign bus.q        = q_r;
  assign bus.q_valid  = qv_r;
endmodule

// File: tb/tb_rr_ff_arbiter.sv
// Directed bench for rr_ff_arbiter (N=4, W=1, MAX_HOLD=2).
// Vector table plus hand sequences for reset, timeout and handoff.
module tb_rr_ff_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;

  rr_ff_arbiter_if #(.N(4), .W(1)) bus ();

  rr_ff_arbiter #(.N(4), .W(1), .MAX_HOLD(2)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic [3:0] din;
    logic [3:0] g;
    logic [1:0] id;
    logic       b;
    logic       q;
    logic       qv;
  } vec_t;

  vec_t tv [19];

  function automatic logic [8:0] obs();
    return {bus.grant, bus.grant_id, bus.busy, bus.q, bus.q_valid};
  endfunction

  task automatic chk(input string name, input logic [8:0] exp);
    logic [8:0] act;
    act = obs();
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got g=%b id=%0d b=%b q=%b qv=%b want g=%b id=%0d b=%b q=%b qv=%b",
               name, act[8:5], act[4:3], act[2], act[1], act[0],
               exp[8:5], exp[4:3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tv[0]  = '{4'b1111, 4'b1111, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b0};
    tv[1]  = '{4'b1111, 4'b1111, 4'b0001, 2'd0, 1'b1, 1'b1, 1'b1};
    tv[2]  = '{4'b1111, 4'b1111, 4'b0010, 2'd1, 1'b1, 1'b1, 1'b1};
    tv[3]  = '{4'b1111, 4'b1111, 4'b0010, 2'd1, 1'b1, 1'b1, 1'b1};
    tv[4]  = '{4'b1111, 4'b1111, 4'b0100, 2'd2, 1'b1, 1'b1, 1'b1};
    tv[5]  = '{4'b1111, 4'b1111, 4'b0100, 2'd2, 1'b1, 1'b1, 1'b1};
    tv[6]  = '{4'b1111, 4'b1111, 4'b1000, 2'd3, 1'b1, 1'b1, 1'b1};
    tv[7]  = '{4'b1111, 4'b1111, 4'b1000, 2'd3, 1'b1, 1'b1, 1'b1};
    tv[8]  = '{4'b1111, 4'b1111, 4'b0001, 2'd0, 1'b1, 1'b1, 1'b1};
    tv[9]  = '{4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b1, 1'b0};
    tv[10] = '{4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1, 1'b0};
    tv[11] = '{4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1, 1'b1};
    tv[12] = '{4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0, 1'b1};
    tv[13] = '{4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1, 1'b1};
    tv[14] = '{4'b0000, 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b1, 1'b0};
    tv[15] = '{4'b0011, 4'b0011, 4'b0001, 2'd0, 1'b1, 1'b1, 1'b0};
    tv[16] = '{4'b0011, 4'b0010, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b1};
    tv[17] = '{4'b0010, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0, 1'b0};
    tv[18] = '{4'b0000, 4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0, 1'b0};

    bus.req = '0;
    bus.din = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_state", 9'b0000_00_0_0_0);
    rst = 1'b0;

    // round robin, single requester, release handoff
    for (int i = 0; i < 19; i++) begin
      bus.req = tv[i].req;
      bus.din = tv[i].din;
      step();
      chk($sformatf("vec%0d", i),
          {tv[i].g, tv[i].id, tv[i].b, tv[i].q, tv[i].qv});
    end

    // asynchronous reset while a grant is active
    bus.req = 4'b0001;
    bus.din = 4'b0001;
    repeat (3) step();
    chk("pre_reset_own", 9'b0001_00_1_1_1);
    #2 rst = 1'b1;
    #1 chk("async_reset", 9'b0000_00_0_0_0);
    #1 rst = 1'b0;
    step();
    chk("post_reset_grant", 9'b0001_00_1_0_0);

    // lone requester hits the hold limit repeatedly and keeps the grant
    bus.req = 4'b1000;
    bus.din = 4'b1000;
    step();
    chk("lone_first", 9'b1000_11_1_0_0);
    for (int i = 1; i < 20; i++) begin
      step();
      chk($sformatf("lone_hold%0d", i), 9'b1000_11_1_1_1);
    end

    // owner drops on the same edge its hold expires
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    bus.req = 4'b1010;
    bus.din = 4'b1010;
    step();
    chk("drop_to_own1", 9'b0010_01_1_0_0);
    step();
    chk("drop_hold_max", 9'b0010_01_1_1_1);
    bus.req = 4'b1000;
    bus.din = 4'b0000;
    step();
    chk("drop_and_timeout", 9'b1000_11_1_1_0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
